// File: rtl/cache_refill_buf.sv
// Line-refill engine: one burst read per miss, collect W beats, commit the full line to the data RAM.
// Optional early-restart (critical word forwarding) is enabled by defining REFILL_EARLY_RESTART_EN.
module cache_refill_buf #(
    parameter int unsigned W     = 4,
    parameter int unsigned LOG_W = 2,
    parameter int unsigned LOG_H = 8,
    parameter int unsigned LOG_N = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_addr,
    input  logic [LOG_H-1:0]     req_index,
    input  logic [LOG_N-1:0]     req_way,
    output logic                 rd_req,
    input  logic                 rd_rdy,
    output logic [31:0]          rd_addr,
    output logic [7:0]           rd_len,
    input  logic                 ret_valid,
    input  logic                 ret_last,
    input  logic [31:0]          ret_data,
    output logic                 ram_replace,
    output logic [LOG_H-1:0]     ram_index,
    output logic [LOG_N-1:0]     ram_way,
    output logic [32*W-1:0]      ram_din,
    output logic                 refill_done,
    output logic                 refill_err,
    output logic                 crit_valid,
    output logic [31:0]          crit_data
);

    localparam int unsigned CW  = LOG_W + 1;   // beat counter also represents "line full" (== W)
    localparam int unsigned OFF = LOG_W + 2;   // byte-offset bits within a line

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [W-1:0][31:0] line_q;
    logic [CW-1:0]      cnt_q;
    logic               err_q;
    logic               accept;
    logic               beat_fits;
    logic               unused_addr_bits;

    assign accept           = (state_q == S_IDLE) && req_valid && req_ready;
    assign beat_fits        = !cnt_q[LOG_W];
    assign rd_len           = 8'(W - 1);
    assign ram_din          = line_q;
    assign unused_addr_bits = ^req_addr[OFF-1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            line_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            req_ready   <= 1'b0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            ram_replace <= 1'b0;
            ram_index   <= '0;
            ram_way     <= '0;
            refill_done <= 1'b0;
            refill_err  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q   <= S_REQ;
                        req_ready <= 1'b0;
                        rd_req    <= 1'b1;
                        rd_addr   <= {req_addr[31:OFF], {OFF{1'b0}}};
                        ram_index <= req_index;
                        ram_way   <= req_way;
                        line_q    <= '0;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (rd_rdy) begin
                        state_q <= S_RECV;
                        rd_req  <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (ret_valid) begin
                        // Beats beyond W are dropped and flag the refill as bad
                        if (beat_fits) begin
                            line_q[cnt_q[LOG_W-1:0]] <= ret_data;
                            cnt_q                    <= cnt_q + CW'(1);
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (ret_last) begin
                            if (cnt_q != CW'(W - 1)) begin
                                err_q <= 1'b1;
                            end
                            state_q     <= S_WRITE;
                            ram_replace <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    state_q     <= S_DONE;
                    ram_replace <= 1'b0;
                    refill_done <= 1'b1;
                    refill_err  <= err_q;
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    refill_done <= 1'b0;
                    refill_err  <= 1'b0;
                    req_ready   <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef REFILL_EARLY_RESTART_EN
    logic [LOG_W-1:0] crit_idx_q;

    // Forward the word the miss actually asked for as soon as it lands
    always_ff @(posedge clk) begin
        if (!resetn) begin
            crit_idx_q <= '0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
        end else begin
            crit_valid <= 1'b0;
            if (accept) begin
                crit_idx_q <= req_addr[OFF-1:2];
            end
            if ((state_q == S_RECV) && ret_valid && beat_fits &&
                (cnt_q[LOG_W-1:0] == crit_idx_q)) begin
                crit_valid <= 1'b1;
                crit_data  <= ret_data;
            end
        end
    end
`else
    assign crit_valid = 1'b0;
    assign crit_data  = 32'h0;
`endif

endmodule

// File: tb/tb_cache_refill_buf.sv
// Directed bench for cache_refill_buf (W=4): normal, stalled, short, long, reset-abort,
// back-to-back and (with REFILL_EARLY_RESTART_EN) critical-word refills.
module tb_cache_refill_buf;

    localparam int unsigned W     = 4;
    localparam int unsigned LOG_W = 2;
    localparam int unsigned LOG_H = 8;
    localparam int unsigned LOG_N = 1;

    logic              clk = 1'b0;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [LOG_H-1:0]  req_index;
    logic [LOG_N-1:0]  req_way;
    logic              rd_req;
    logic              rd_rdy;
    logic [31:0]       rd_addr;
    logic [7:0]        rd_len;
    logic              ret_valid;
    logic              ret_last;
    logic [31:0]       ret_data;
    logic              ram_replace;
    logic [LOG_H-1:0]  ram_index;
    logic [LOG_N-1:0]  ram_way;
    logic [32*W-1:0]   ram_din;
    logic              refill_done;
    logic              refill_err;
    logic              crit_valid;
    logic [31:0]       crit_data;

    cache_refill_buf #(.W(W), .LOG_W(LOG_W), .LOG_H(LOG_H), .LOG_N(LOG_N)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_index(req_index), .req_way(req_way),
        .rd_req(rd_req), .rd_rdy(rd_rdy), .rd_addr(rd_addr), .rd_len(rd_len),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .ram_replace(ram_replace), .ram_index(ram_index), .ram_way(ram_way), .ram_din(ram_din),
        .refill_done(refill_done), .refill_err(refill_err),
        .crit_valid(crit_valid), .crit_data(crit_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event recorder, sampled mid-cycle
    int           rep_cnt = 0, done_cnt = 0, crit_cnt = 0;
    int           rep_cyc = -1, done_cyc = -1, crit_cyc = -1;
    logic [127:0] rep_din = '0;
    logic [7:0]   rep_idx = '0;
    logic [0:0]   rep_way = '0;
    logic         done_err = 1'b0;
    logic [31:0]  crit_dat = '0;

    always @(negedge clk) begin
        if (ram_replace) begin
            rep_cnt++;
            rep_cyc = cyc;
            rep_din = ram_din;
            rep_idx = ram_index;
            rep_way = ram_way;
        end
        if (refill_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = refill_err;
        end
        if (crit_valid) begin
            crit_cnt++;
            crit_cyc = cyc;
            crit_dat = crit_data;
        end
    end

    logic [31:0] beat_d [8];
    int          beat_gap [8];
    int          beat_cyc [8];
    int          nbeats;
    int          last_at;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beats(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                             input logic [31:0] b3, input logic [31:0] b4, input int n, input int last);
        beat_d[0] = b0; beat_d[1] = b1; beat_d[2] = b2; beat_d[3] = b3; beat_d[4] = b4;
        for (int i = 0; i < 8; i++) beat_gap[i] = 0;
        nbeats  = n;
        last_at = last;
    endtask

    task automatic accept_wait(input string pfx, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            if (req_ready) begin
                got = 1'b1;
                acc = cyc;
            end
            tick();
        end
        check({pfx, ".accept"}, 128'(got), 128'(1));
    endtask

    task automatic burst(input string pfx, input int rdy_delay, input bit stray, input logic [31:0] exp_addr);
        for (int i = 0; i < rdy_delay; i++) begin
            rd_rdy = 1'b0;
            if (stray) begin
                ret_valid = 1'b1;
                ret_last  = (i == 0);
                ret_data  = 32'hBAD0_0000 | 32'(i);
            end
            check({pfx, ".rd_req_hold"}, 128'(rd_req), 128'(1));
            check({pfx, ".rd_addr_hold"}, 128'(rd_addr), 128'(exp_addr));
            tick();
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        rd_rdy    = 1'b1;
        check({pfx, ".rd_req"}, 128'(rd_req), 128'(1));
        check({pfx, ".rd_addr"}, 128'(rd_addr), 128'(exp_addr));
        check({pfx, ".rd_len"}, 128'(rd_len), 128'(3));
        tick();
        rd_rdy = 1'b0;
        check({pfx, ".rd_req_drop"}, 128'(rd_req), 128'(0));
        for (int i = 0; i < nbeats; i++) begin
            for (int g = 0; g < beat_gap[i]; g++) tick();
            ret_valid   = 1'b1;
            ret_data    = beat_d[i];
            ret_last    = (i == last_at);
            beat_cyc[i] = cyc;
            tick();
            ret_valid = 1'b0;
            ret_last  = 1'b0;
        end
    endtask

    task automatic wait_done(input string pfx, input int target);
        for (int i = 0; i < 60 && done_cnt < target; i++) tick();
        check({pfx, ".done_seen"}, 128'(done_cnt >= target), 128'(1));
    endtask

    task automatic check_refill(input string pfx, input logic [127:0] exp_din, input int idx, input int way,
                                input bit err, input int lat, input int acc, input int rep_base, input int done_base);
        check({pfx, ".replace_cnt"}, 128'(rep_cnt - rep_base), 128'(1));
        check({pfx, ".replace_at"}, 128'(rep_cyc - acc), 128'(lat - 1));
        check({pfx, ".din"}, rep_din, exp_din);
        check({pfx, ".idx"}, 128'(rep_idx), 128'(idx));
        check({pfx, ".way"}, 128'(rep_way), 128'(way));
        check({pfx, ".done_cnt"}, 128'(done_cnt - done_base), 128'(1));
        check({pfx, ".latency"}, 128'(done_cyc - acc), 128'(lat));
        check({pfx, ".err"}, 128'(done_err), 128'(err));
        check({pfx, ".din_hold"}, ram_din, exp_din);
        check({pfx, ".ready_after"}, 128'(req_ready), 128'(1));
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, ".req_ready"}, 128'(req_ready), 128'(0));
        check({pfx, ".rd_req"}, 128'(rd_req), 128'(0));
        check({pfx, ".rd_addr"}, 128'(rd_addr), 128'(0));
        check({pfx, ".rd_len"}, 128'(rd_len), 128'(3));
        check({pfx, ".ram_replace"}, 128'(ram_replace), 128'(0));
        check({pfx, ".ram_index"}, 128'(ram_index), 128'(0));
        check({pfx, ".ram_way"}, 128'(ram_way), 128'(0));
        check({pfx, ".ram_din"}, ram_din, 128'(0));
        check({pfx, ".refill_done"}, 128'(refill_done), 128'(0));
        check({pfx, ".refill_err"}, 128'(refill_err), 128'(0));
        check({pfx, ".crit_valid"}, 128'(crit_valid), 128'(0));
        check({pfx, ".crit_data"}, 128'(crit_data), 128'(0));
    endtask

    int acc, acc2, rep_base, done_base, done1;

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_index = '0;
        req_way   = '0;
        rd_rdy    = 1'b0;
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        ret_data  = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        resetn = 1'b1;
        tick();
        check("reset.ready_release", 128'(req_ready), 128'(1));

        // Case 1: nominal refill
        rep_base = rep_cnt; done_base = done_cnt;
        req_valid = 1'b1; req_addr = 32'h1C00_0014; req_index = 8'd5; req_way = 1'b1;
        set_beats(32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333, 32'h0, 4, 3);
        accept_wait("t1", acc);
        req_valid = 1'b0;
        burst("t1", 0, 1'b0, 32'h1C00_0010);
        wait_done("t1", done_base + 1);
        check_refill("t1", {32'hA333_3333, 32'hA222_2222, 32'hA111_1111, 32'hA000_0000},
                     5, 1, 1'b0, 7, acc, rep_base, done_base);

        // Case 2: bridge stalls 5 cycles while stray beats appear
        rep_base = rep_cnt; done_base = done_cnt;
        req_valid = 1'b1; req_addr = 32'h0000_1238; req_index = 8'hAA; req_way = 1'b0;
        set_beats(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h0, 4, 3);
        accept_wait("t2", acc);
        req_valid = 1'b0;
        burst("t2", 5, 1'b1, 32'h0000_1230);
        wait_done("t2", done_base + 1);
        check_refill("t2", {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                     8'hAA, 0, 1'b0, 12, acc, rep_base, done_base);

        // Case 3: short burst, last on second beat
        rep_base = rep_cnt; done_base = done_cnt;
        req_valid = 1'b1; req_addr = 32'hFFFF_FFFF; req_index = 8'hFF; req_way = 1'b1;
        set_beats(32'hB000_00B0, 32'hB000_00B1, 32'h0, 32'h0, 32'h0, 2, 1);
        accept_wait("t3", acc);
        req_valid = 1'b0;
        burst("t3", 0, 1'b0, 32'hFFFF_FFF0);
        wait_done("t3", done_base + 1);
        check_refill("t3", {32'h0, 32'h0, 32'hB000_00B1, 32'hB000_00B0},
                     8'hFF, 1, 1'b1, 5, acc, rep_base, done_base);

        // Case 3b: long burst, fifth beat must not overwrite anything
        rep_base = rep_cnt; done_base = done_cnt;
        req_valid = 1'b1; req_addr = 32'h0000_0080; req_index = 8'd7; req_way = 1'b0;
        set_beats(32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003, 32'hE000_0004, 5, 4);
        accept_wait("t3b", acc);
        req_valid = 1'b0;
        burst("t3b", 0, 1'b0, 32'h0000_0080);
        wait_done("t3b", done_base + 1);
        check_refill("t3b", {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000},
                     7, 0, 1'b1, 8, acc, rep_base, done_base);

        // Case 4: reset in the middle of a burst
        req_valid = 1'b1; req_addr = 32'h0000_0040; req_index = 8'd3; req_way = 1'b0;
        set_beats(32'hC0C0_0000, 32'hC0C0_0001, 32'h0, 32'h0, 32'h0, 2, 99);
        accept_wait("t4", acc);
        req_valid = 1'b0;
        burst("t4", 0, 1'b0, 32'h0000_0040);
        rep_base = rep_cnt; done_base = done_cnt;
        resetn = 1'b0; ret_valid = 1'b1; ret_last = 1'b0; ret_data = 32'h5555_5555;
        tick();
        check_reset_outputs("t4rst");
        resetn = 1'b1; ret_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) check("t4.ready_release", 128'(req_ready), 128'(1));
        end
        ret_valid = 1'b0; ret_last = 1'b0;
        tick();
        check("t4.no_replace", 128'(rep_cnt - rep_base), 128'(0));
        check("t4.no_done", 128'(done_cnt - done_base), 128'(0));
        check("t4.din_clear", ram_din, 128'(0));
        req_valid = 1'b1; req_addr = 32'h0000_0F0C; req_index = 8'd9; req_way = 1'b1;
        set_beats(32'hF000_0000, 32'hF000_0001, 32'hF000_0002, 32'hF000_0003, 32'h0, 4, 3);
        accept_wait("t4c", acc);
        req_valid = 1'b0;
        burst("t4c", 0, 1'b0, 32'h0000_0F00);
        wait_done("t4c", done_base + 1);
        check_refill("t4c", {32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000},
                     9, 1, 1'b0, 7, acc, rep_base, done_base);

        // Case 5: back-to-back with req_valid held high
        rep_base = rep_cnt; done_base = done_cnt;
        req_valid = 1'b1; req_addr = 32'h0000_2000; req_index = 8'd1; req_way = 1'b0;
        set_beats(32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 32'h6000_0003, 32'h0, 4, 3);
        accept_wait("t5a", acc);
        req_addr = 32'h0000_3004; req_index = 8'd2; req_way = 1'b1;
        burst("t5a", 0, 1'b0, 32'h0000_2000);
        accept_wait("t5b", acc2);
        req_valid = 1'b0;
        done1 = done_cyc;
        check("t5a.done_cnt", 128'(done_cnt - done_base), 128'(1));
        check("t5a.latency", 128'(done1 - acc), 128'(7));
        check("t5a.din", rep_din, {32'h6000_0003, 32'h6000_0002, 32'h6000_0001, 32'h6000_0000});
        check("t5a.replace_cnt", 128'(rep_cnt - rep_base), 128'(1));
        check("t5.b2b_gap", 128'(acc2 - done1), 128'(1));
        rep_base = rep_cnt; done_base = done_cnt;
        set_beats(32'h7000_0000, 32'h7000_0001, 32'h7000_0002, 32'h7000_0003, 32'h0, 4, 3);
        burst("t5b", 0, 1'b0, 32'h0000_3000);
        wait_done("t5b", done_base + 1);
        check_refill("t5b", {32'h7000_0003, 32'h7000_0002, 32'h7000_0001, 32'h7000_0000},
                     2, 1, 1'b0, 7, acc2, rep_base, done_base);

`ifdef REFILL_EARLY_RESTART_EN
        // Case 6: critical word is word 2, beats arrive with gaps
        rep_base = rep_cnt; done_base = done_cnt;
        req_valid = 1'b1; req_addr = 32'h2000_0008; req_index = 8'h44; req_way = 1'b0;
        set_beats(32'hCC00_0000, 32'hCC00_0001, 32'hCC00_0002, 32'hCC00_0003, 32'h0, 4, 3);
        beat_gap[1] = 2;
        beat_gap[2] = 1;
        acc2 = crit_cnt;
        accept_wait("t6", acc);
        req_valid = 1'b0;
        burst("t6", 0, 1'b0, 32'h2000_0000);
        wait_done("t6", done_base + 1);
        check_refill("t6", {32'hCC00_0003, 32'hCC00_0002, 32'hCC00_0001, 32'hCC00_0000},
                     8'h44, 0, 1'b0, 10, acc, rep_base, done_base);
        check("t6.crit_cnt", 128'(crit_cnt - acc2), 128'(1));
        check("t6.crit_at", 128'(crit_cyc - beat_cyc[2]), 128'(1));
        check("t6.crit_data", 128'(crit_dat), 128'(32'hCC00_0002));
`else
        check("nocrit.cnt", 128'(crit_cnt), 128'(0));
        check("nocrit.data", 128'(crit_data), 128'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
